wb_uart_poller: RTL
===================

Name: wb_uart_poller

Overview:
- Wishbone initiator that drives a wb_uart-style responder: status register at BASE_ADDR+0x00, data register at BASE_ADDR+0x04.
- Polls the status register (UCR) continuously.
- Reads received bytes into a local valid/ready output.
- Writes bytes from a local valid/ready input only when UCR.tx_busy=0, so no write is silently dropped.
- Sits between a byte-stream client (command parser, LCD text feeder) and the UART on the shared bus.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the UART register block.
- TIMEOUT, 255, max cycles to wait for wb_ack_i before aborting a cycle (range 1..65535).
- SETTLE, 2, idle cycles after a DATA write before the next UCR poll, so tx_busy becomes visible.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- wb_cyc_o, output, 1, bus cycle.
- wb_stb_o, output, 1, strobe.
- wb_we_o, output, 1, write enable.
- wb_adr_o, output, 32, address.
- wb_sel_o, output, 4, byte select.
- wb_dat_o, output, 32, write data.
- wb_dat_i, input, 32, read data.
- wb_ack_i, input, 1, acknowledge.
- tx_byte, input, 8, byte to send.
- tx_valid, input, 1, tx_byte valid.
- tx_ready, output, 1, holding register empty.
- rx_byte, output, 8, received byte.
- rx_valid, output, 1, rx_byte valid.
- rx_ready, input, 1, consumer accepts rx_byte.
- bus_err, output, 1, sticky: a cycle timed out.

Behaviour:
- Reset (async, immediate) values:
  - wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_sel_o=0, wb_dat_o=0.
  - tx_ready=1, rx_valid=0, rx_byte=0, bus_err=0.
  - State=POLL, holding register empty, settle and timeout counters=0.
- Reset mid-cycle drops cyc/stb in the same instant. A pending tx byte is lost.
- All bus outputs are registered. wb_cyc_o and wb_stb_o are asserted together and held until the ack cycle or a timeout.
- Both strobes drop on the clock edge that samples wb_ack_i=1. The responder's ack is combinational on stb, so stb must not stay high past the ack cycle, or a second access is produced.
- Tx holding register:
  - tx_ready = holding register empty.
  - Transfer occurs on clk when tx_valid & tx_ready; tx_ready goes 0 the next cycle.
  - The register is cleared when the write to DATA is acked.
- States:
  - POLL: issue read, adr=BASE_ADDR, we=0, sel=4'hF. On ack, latch UCR = wb_dat_i[7:0] and go to DECIDE.
  - DECIDE: one cycle, priority in this order:
    1. If UCR[0] (rx_avail) = 1 and rx_valid = 0, go to RD_DATA.
    2. Else if the holding register is full and UCR[4] (tx_busy) = 0, go to WR_DATA.
    3. Else go to POLL.
  - RD_DATA: read, adr=BASE_ADDR+4, sel=4'hF. On ack: rx_byte=wb_dat_i[7:0], rx_valid=1, go to POLL.
  - WR_DATA: write, adr=BASE_ADDR+4, we=1, sel=4'b0001, wb_dat_o={24'b0, held byte}. On ack go to SETTLE.
  - SETTLE: count SETTLE cycles with the bus idle, then go to POLL. SETTLE=0 means go directly to POLL.
- Rx output:
  - rx_valid holds until rx_valid & rx_ready, then clears the next cycle.
  - While rx_valid=1, DATA is never read. Backpressure is left to the UART's rx_avail.
- Timeout:
  - The counter resets at each strobe assertion and increments while strobe is high and ack is low.
  - When count reaches TIMEOUT: drop cyc/stb, set bus_err (cleared only by reset), go to POLL.
  - A timed-out write keeps its byte held for retry. A timed-out read delivers nothing.
- Ack arriving together with a timeout expiry is treated as a valid ack.

Optional Feature:
- Macro WB_UART_POLLER_RXERR_EN.
- When defined, DECIDE first checks UCR[1] (rx_error). If set, it reads DATA to flush it and discards the byte (rx_valid is not set), then pulses output rx_err (1 cycle) and goes to POLL. Port rx_err exists only with the macro.
- Without the macro, rx_error is ignored and the byte is delivered normally.

Test Plan:
- Idle poll: UCR model returns 8'h00 -> repeated reads at BASE_ADDR only, stb high exactly until the ack cycle, no DATA access, tx_ready=1.
- Transmit: tx_byte=8'hA5 with tx_valid for 1 cycle, UCR tx_busy=0 -> one write at BASE_ADDR+4, sel=4'b0001, dat=32'h0000_00A5. Then SETTLE=2 idle cycles before the next poll; tx_ready returns to 1.
- Tx busy hold: UCR=8'h10 for 5 polls, then 8'h00 -> no write during the busy polls, then exactly one write of the held byte.
- Receive with backpressure: UCR=8'h01, DATA=8'h3C, rx_ready=0 -> rx_byte=8'h3C, rx_valid=1, and no further DATA reads while rx_ready=0. Raising rx_ready clears rx_valid next cycle.
- Rx priority: tx pending and UCR=8'h01 in the same poll -> DATA read precedes the DATA write.
- Timeout and reset: responder never acks with TIMEOUT=8 -> stb drops after 8 cycles and bus_err=1. Asserting reset mid-cycle -> cyc/stb=0 immediately and bus_err=0.

Source files
------------

// File: rtl/wb_uart_poller_if.sv
// Wishbone bus bundle between the UART poller (master side) and a wb_uart-style
// register block (slave side).
interface wb_uart_poller_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_uart_poller.sv
// Wishbone initiator that polls a UART status register and moves bytes between
// local valid/ready streams and the UART data register. Optional rx-error flush: WB_UART_POLLER_RXERR_EN.
//
// state    | meaning
// POLL     | read status register (UCR) at BASE_ADDR
// DECIDE   | pick next access from latched UCR
// RD_DATA  | read data register into rx_byte (or flush it on rx error)
// WR_DATA  | write held tx byte to data register
// SETTLE   | bus idle for SETTLE cycles so tx_busy becomes visible
module wb_uart_poller #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 255,
  parameter int          SETTLE    = 2
) (
  input  logic              clk,
  input  logic              reset,
  wb_uart_poller_if.master  wb,
  input  logic [7:0]        tx_byte,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [7:0]        rx_byte,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              bus_err
`ifdef WB_UART_POLLER_RXERR_EN
  ,output logic             rx_err
`endif
);

  typedef enum logic [2:0] {ST_POLL, ST_DECIDE, ST_RD_DATA, ST_WR_DATA, ST_SETTLE} state_t;

  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);

  state_t      state_q, state_d;
  logic        stb_q, stb_d, we_q, we_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  settle_q, settle_d;
  logic        rx_avail_q, rx_avail_d, tx_busy_q, tx_busy_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d, bus_err_q, bus_err_d;
`ifdef WB_UART_POLLER_RXERR_EN
  logic        rx_error_q, rx_error_d, flush_q, flush_d, rx_err_q, rx_err_d;
`endif

  logic unused_dat_hi;
  assign unused_dat_hi = ^wb.wb_dat_i[31:8];

  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    timer_d     = timer_q;
    settle_d    = settle_q;
    rx_avail_d  = rx_avail_q;
    tx_busy_d   = tx_busy_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = rx_valid_q;
    bus_err_d   = bus_err_q;
`ifdef WB_UART_POLLER_RXERR_EN
    rx_error_d  = rx_error_q;
    flush_d     = flush_q;
    rx_err_d    = 1'b0;
`endif

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_byte;
      hold_full_d = 1'b1;
    end
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      ST_POLL, ST_RD_DATA, ST_WR_DATA: begin
        // Each access starts from an idle bus cycle, so stb never stays high past an ack.
        if (!stb_q) begin
          stb_d   = 1'b1;
          timer_d = 16'd0;
          adr_d   = (state_q == ST_POLL) ? BASE_ADDR : BASE_ADDR + 32'h4;
          we_d    = (state_q == ST_WR_DATA);
          sel_d   = (state_q == ST_WR_DATA) ? 4'b0001 : 4'hF;
          dat_d   = (state_q == ST_WR_DATA) ? {24'h0, hold_q} : 32'h0;
        end else if (wb.wb_ack_i) begin
          stb_d = 1'b0;
          we_d  = 1'b0;
          adr_d = 32'h0;
          sel_d = 4'h0;
          dat_d = 32'h0;
          case (state_q)
            ST_POLL: begin
              rx_avail_d = wb.wb_dat_i[0];
              tx_busy_d  = wb.wb_dat_i[4];
`ifdef WB_UART_POLLER_RXERR_EN
              rx_error_d = wb.wb_dat_i[1];
`endif
              state_d    = ST_DECIDE;
            end
            ST_RD_DATA: begin
`ifdef WB_UART_POLLER_RXERR_EN
              if (flush_q) begin
                flush_d  = 1'b0;
                rx_err_d = 1'b1;
              end else
`endif
              begin
                rx_byte_d  = wb.wb_dat_i[7:0];
                rx_valid_d = 1'b1;
              end
              state_d = ST_POLL;
            end
            default: begin
              hold_full_d = 1'b0;
              settle_d    = 8'd0;
              state_d     = (SETTLE == 0) ? ST_POLL : ST_SETTLE;
            end
          endcase
        end else if (timer_q == TO_LAST) begin
          // Abandoned cycle: a held tx byte stays for retry, a read delivers nothing.
          stb_d     = 1'b0;
          we_d      = 1'b0;
          adr_d     = 32'h0;
          sel_d     = 4'h0;
          dat_d     = 32'h0;
          bus_err_d = 1'b1;
          state_d   = ST_POLL;
`ifdef WB_UART_POLLER_RXERR_EN
          flush_d   = 1'b0;
`endif
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_DECIDE: begin
        state_d = ST_POLL;
`ifdef WB_UART_POLLER_RXERR_EN
        if (rx_error_q) begin
          state_d = ST_RD_DATA;
          flush_d = 1'b1;
        end else
`endif
        if (rx_avail_q && !rx_valid_q) state_d = ST_RD_DATA;
        else if (hold_full_q && !tx_busy_q) state_d = ST_WR_DATA;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = ST_POLL;
        else settle_d = settle_q + 8'd1;
      end
      default: state_d = ST_POLL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_POLL;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'h0;
      sel_q       <= 4'h0;
      dat_q       <= 32'h0;
      timer_q     <= 16'd0;
      settle_q    <= 8'd0;
      rx_avail_q  <= 1'b0;
      tx_busy_q   <= 1'b0;
      hold_q      <= 8'h0;
      hold_full_q <= 1'b0;
      rx_byte_q   <= 8'h0;
      rx_valid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
`ifdef WB_UART_POLLER_RXERR_EN
      rx_error_q  <= 1'b0;
      flush_q     <= 1'b0;
      rx_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      timer_q     <= timer_d;
      settle_q    <= settle_d;
      rx_avail_q  <= rx_avail_d;
      tx_busy_q   <= tx_busy_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      bus_err_q   <= bus_err_d;
`ifdef WB_UART_POLLER_RXERR_EN
      rx_error_q  <= rx_error_d;
      flush_q     <= flush_d;
      rx_err_q    <= rx_err_d;
`endif
    end
  end

  assign wb.wb_cyc_o = stb_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_dat_o = dat_q;
  assign tx_ready    = !hold_full_q;
  assign rx_byte     = rx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign bus_err     = bus_err_q;
`ifdef WB_UART_POLLER_RXERR_EN
  assign rx_err      = rx_err_q;
`endif

endmodule
